// File: rtl/controller_pkg.sv
// Shared types and constants for the BNN training controller.
// Field positions describe the 32-bit mode command word.
package controller_pkg;

    localparam int unsigned MAXLEN  = 256;
    localparam int unsigned LANES   = 8;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned DELTA_W = 5;

    localparam int unsigned OP_LSB   = 0;
    localparam int unsigned OP_MSB   = 3;
    localparam int unsigned DIR_BIT  = 4;
    localparam int unsigned TGT_BIT  = 7;
    localparam int unsigned LEN_LSB  = 8;
    localparam int unsigned LEN_MSB  = 11;
    localparam int unsigned PASS_LSB = 12;
    localparam int unsigned PASS_MSB = 15;

    typedef enum logic [3:0] {
        OP_IDLE = 4'd0,
        OP_RUN  = 4'd1,
        OP_LOAD = 4'd2
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        RESULT,
        HOLD
    } state_e;

    // Length exponent saturates at log2(MAXLEN).
    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        return (l > 4'd8) ? 4'd8 : l;
    endfunction

endpackage

// File: rtl/controller_xnor_popcount8.sv
// Signed XNOR-popcount of one 8-bit lane group: +1 per matching valid bit,
// -1 per mismatching valid bit, 0 for masked bits.
module xnor_popcount8
    import controller_pkg::*;
(
    input  logic [LANES-1:0]          w,
    input  logic [LANES-1:0]          a,
    input  logic [LANES-1:0]          valid,
    output logic signed [DELTA_W-1:0] delta
);

    always_comb begin
        delta = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (valid[k]) begin
                delta = (w[k] ~^ a[k]) ? delta + 5'sd1 : delta - 5'sd1;
            end
        end
    end

endmodule

// File: rtl/controller.sv
// BNN training controller: serial weight/activation loader plus an FSM running
// XNOR-popcount forward sweeps and sign-perceptron weight-update sweeps.
module controller
    import controller_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [31:0]        mode,
    input  logic signed [31:0] in_data,
    output logic signed [31:0] out_data,
    output logic               out_sign,
    output logic               busy,
    output logic               done
);

    state_e state_q, state_d;

    logic [MAXLEN-1:0] wmem, amem;
    logic [IDX_W-1:0]  ptr_q, ptr_eff;
    logic [3:0]        prev_op_q;
    logic              prev_tgt_q;

    logic              dir_q, t_q, y_q;
    logic [3:0]        len_q, pass_q;
    logic [IDX_W-1:0]  idx_q;
    logic signed [31:0] acc_q;

    logic [3:0]        op;
    logic              tgt;
    logic              load_en;
    logic              start, sweep, result;
    logic [IDX_W:0]    len_bits, idx_step;
    logic              last_chunk;
    logic [LANES-1:0]  valid, w_chunk, a_chunk, flip;
    logic signed [DELTA_W-1:0] delta;
    logic              unused;

    assign op     = mode[OP_MSB:OP_LSB];
    assign tgt    = mode[TGT_BIT];
    assign unused = ^{in_data[31:1], mode[31:16], mode[6:5]};

    assign busy    = (state_q == SWEEP) || (state_q == RESULT);
    assign load_en = (op == OP_LOAD) && !busy;
    // A change of op or target since the last enabled cycle restarts the load at bit 0.
    assign ptr_eff = ((op != prev_op_q) || (tgt != prev_tgt_q)) ? '0 : ptr_q;

    assign len_bits   = 9'd1 << len_q;
    assign idx_step   = {1'b0, idx_q} + 9'd8;
    assign last_chunk = idx_step >= len_bits;
    assign w_chunk    = wmem[idx_q +: LANES];
    assign a_chunk    = amem[idx_q +: LANES];

    always_comb begin
        valid = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            valid[k] = ({1'b0, idx_q} + 9'(k)) < len_bits;
        end
    end

    // Weights flip only when the captured prediction was wrong and the bit disagrees with t.
    always_comb begin
        flip = '0;
        if (dir_q && (y_q != t_q)) begin
            flip = valid & (~(w_chunk ^ a_chunk) ^ {LANES{t_q}});
        end
    end

    xnor_popcount8 u_pop (
        .w     (w_chunk),
        .a     (a_chunk),
        .valid (valid),
        .delta (delta)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        sweep   = 1'b0;
        result  = 1'b0;
        case (state_q)
            IDLE: begin
                if (op == OP_RUN) begin
                    start   = 1'b1;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                sweep = 1'b1;
                if (last_chunk) state_d = RESULT;
            end
            RESULT: begin
                result  = 1'b1;
                state_d = (pass_q > 4'd1) ? SWEEP : HOLD;
            end
            HOLD: begin
                if (op != OP_RUN) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else if (enable) state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) done <= 1'b0;
        else done <= enable && (state_q == RESULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wmem       <= '0;
            amem       <= '0;
            ptr_q      <= '0;
            prev_op_q  <= '0;
            prev_tgt_q <= 1'b0;
            dir_q      <= 1'b0;
            t_q        <= 1'b0;
            y_q        <= 1'b0;
            len_q      <= '0;
            pass_q     <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            out_data   <= '0;
            out_sign   <= 1'b0;
        end else if (enable) begin
            prev_op_q  <= op;
            prev_tgt_q <= tgt;
            if (load_en) begin
                if (tgt) wmem[ptr_eff] <= in_data[0];
                else     amem[ptr_eff] <= in_data[0];
                ptr_q <= ptr_eff + 8'd1;
            end else begin
                ptr_q <= ptr_eff;
            end

            if (start) begin
                dir_q  <= mode[DIR_BIT];
                t_q    <= in_data[0];
                y_q    <= out_sign;
                len_q  <= clamp_len(mode[LEN_MSB:LEN_LSB]);
                pass_q <= (mode[PASS_MSB:PASS_LSB] == 4'd0) ? 4'd1 : mode[PASS_MSB:PASS_LSB];
                acc_q  <= '0;
                idx_q  <= '0;
            end else if (sweep) begin
                acc_q <= acc_q + 32'(delta);
                idx_q <= idx_q + 8'd8;
                wmem[idx_q +: LANES] <= w_chunk ^ flip;
            end else if (result) begin
                out_data <= acc_q;
                out_sign <= ~acc_q[31];
                acc_q    <= '0;
                idx_q    <= '0;
                pass_q   <= pass_q - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_controller.sv
// Directed self-checking bench for the BNN training controller.
module tb_controller;

    logic               clk;
    logic               reset;
    logic               enable;
    logic [31:0]        mode;
    logic signed [31:0] in_data;
    logic signed [31:0] out_data;
    logic               out_sign;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    int          ndone;
    int          busy_cnt;
    logic [31:0] res [4];
    logic [31:0] sgn [4];
    int          lat [4];

    controller dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .in_data  (in_data),
        .out_data (out_data),
        .out_sign (out_sign),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic tgt, input int n, input logic val, input logic lastval);
        mode    = 32'h0;
        in_data = '0;
        tick();
        mode = tgt ? 32'h82 : 32'h02;
        for (int i = 0; i < n; i++) begin
            in_data = {31'd0, (i == n - 1) ? lastval : val};
            tick();
        end
        mode    = 32'h0;
        in_data = '0;
        tick();
    endtask

    task automatic run(input logic [31:0] m, input logic t, input int npass, input int freeze_at);
        int cyc;
        ndone    = 0;
        busy_cnt = 0;
        cyc      = 0;
        mode     = m;
        in_data  = {31'd0, t};
        while (ndone < npass && cyc < 2000) begin
            tick();
            cyc++;
            if (busy) busy_cnt++;
            if (done) begin
                if (ndone < 4) begin
                    res[ndone] = out_data;
                    sgn[ndone] = {31'd0, out_sign};
                    lat[ndone] = cyc;
                end
                ndone++;
            end
            if (freeze_at > 0 && cyc == freeze_at)     enable = 1'b0;
            if (freeze_at > 0 && cyc == freeze_at + 5) enable = 1'b1;
        end
        check("run_done_count", ndone, npass);
        mode    = 32'h0;
        in_data = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) ndone++;
        end
        check("no_extra_done", ndone, npass);
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b1;
        mode    = '0;
        in_data = '0;
        repeat (3) tick();
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_sign", {31'd0, out_sign}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_done", {31'd0, done}, 32'h0);
        reset = 1'b1;
        tick();

        // 1: all ones both sides
        load(1'b1, 256, 1'b1, 1'b1);
        load(1'b0, 256, 1'b1, 1'b1);
        run(32'h1801, 1'b0, 1, 0);
        check("t1_latency", lat[0], 34);
        check("t1_busy_cycles", busy_cnt, 33);
        check("t1_out_data", res[0], 32'd256);
        check("t1_out_sign", sgn[0], 32'd1);

        // 2: activations zero
        load(1'b0, 256, 1'b0, 1'b0);
        run(32'h1801, 1'b0, 1, 0);
        check("t2_out_data", res[0], 32'hFFFF_FF00);
        check("t2_out_sign", sgn[0], 32'd0);

        // 3: backward, two passes; first pass flips every weight to 0
        run(32'h2811, 1'b1, 2, 0);
        check("t3_p1_data", res[0], 32'hFFFF_FF00);
        check("t3_p1_latency", lat[0], 34);
        check("t3_p2_data", res[1], 32'd256);
        check("t3_p2_latency", lat[1], 67);
        run(32'h1801, 1'b0, 1, 0);
        check("t3_fwd_data", res[0], 32'd256);

        // 4: 257-bit load wraps and overwrites bit 0 with 0
        load(1'b1, 257, 1'b1, 1'b0);
        load(1'b0, 256, 1'b1, 1'b1);
        run(32'h1801, 1'b0, 1, 0);
        check("t4_out_data", res[0], 32'd254);
        check("t4_out_sign", sgn[0], 32'd1);

        // 5: freeze five cycles mid-sweep
        run(32'h1801, 1'b0, 1, 10);
        check("t5_latency", lat[0], 39);
        check("t5_out_data", res[0], 32'd254);

        // length boundaries: 2^2 bits, 2^4 bits, clamp of 15, zero passes
        run(32'h1201, 1'b0, 1, 0);
        check("len4_data", res[0], 32'd2);
        check("len4_latency", lat[0], 3);
        run(32'h1401, 1'b0, 1, 0);
        check("len16_data", res[0], 32'd14);
        check("len16_latency", lat[0], 4);
        run(32'h1F01, 1'b0, 1, 0);
        check("lenclamp_data", res[0], 32'd254);
        check("lenclamp_latency", lat[0], 34);
        run(32'h0801, 1'b0, 1, 0);
        check("pass0_data", res[0], 32'd254);

        // 6: async reset mid-sweep
        mode    = 32'h1801;
        in_data = '0;
        repeat (10) tick();
        check("t6_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("t6_out_data", out_data, 32'h0);
        check("t6_out_sign", {31'd0, out_sign}, 32'h0);
        check("t6_busy", {31'd0, busy}, 32'h0);
        check("t6_done", {31'd0, done}, 32'h0);
        mode = 32'h0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        run(32'h1801, 1'b0, 1, 0);
        check("t6_after_data", res[0], 32'd256);
        check("t6_after_latency", lat[0], 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
